// File: rtl/bank_burst_ctrl.sv
// bank_burst_ctrl
// ----------------
// Turns single burst commands into BL = 2**BLWIDTH consecutive Bank column
// accesses, one beat per cycle. Beat addresses wrap inside the BL-aligned
// column block starting at the critical column. Read beats launch a token
// into an RD_LAT-deep pipeline, so rd_valid lines up with the Bank's dqout.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   command handshake (ready only while idle)
//   cmd_wr            0 = read burst, 1 = write burst
//   cmd_row, cmd_col  target row and critical column, sampled on accept
//   wr_data, wr_beat  write beat data in; wr_beat marks the cycles it is used
//   rd_data, rd_valid read beat data out
//   rd_o_wr, dqin,    Bank command/write-data/read-data/address signals
//   dqout, row,
//   column
//   busy              burst in progress or read data still in flight
module bank_burst_ctrl #(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int BLWIDTH      = 3,
  parameter int RD_LAT       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_wr,
  input  logic [CHWIDTH-1:0]      cmd_row,
  input  logic [COLWIDTH-1:0]     cmd_col,
  input  logic [DEVICE_WIDTH-1:0] wr_data,
  output logic                    wr_beat,
  output logic [DEVICE_WIDTH-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_o_wr,
  output logic [DEVICE_WIDTH-1:0] dqin,
  input  logic [DEVICE_WIDTH-1:0] dqout,
  output logic [CHWIDTH-1:0]      row,
  output logic [COLWIDTH-1:0]     column,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic [BLWIDTH-1:0]    beat_reg, beat_next;
  logic [CHWIDTH-1:0]    row_reg, row_next;
  logic [COLWIDTH-1:0]   col_reg, col_next;
  logic [RD_LAT-1:0]     tok_reg, tok_next;
  logic                  last_beat;

  // The beat counter is exactly BLWIDTH bits wide, so the last beat is all ones.
  assign last_beat = &beat_reg;

  // Next-state and address sequencing. The column register already holds the
  // current beat address; the next beat only advances its low BLWIDTH bits,
  // which wrap naturally and can never carry into the upper column bits.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = cmd_wr ? WRITE : READ;
          beat_next  = '0;
          row_next   = cmd_row;
          col_next   = cmd_col;
        end
      end
      WRITE, READ: begin
        if (last_beat) begin
          // Address stays on the last beat while idle.
          state_next = IDLE;
          beat_next  = '0;
        end else begin
          beat_next = beat_reg + 1'b1;
          col_next  = {col_reg[COLWIDTH-1:BLWIDTH],
                       col_reg[BLWIDTH-1:0] + {{(BLWIDTH-1){1'b0}}, 1'b1}};
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  // Read token pipeline: a token enters on every read beat and emerges
  // RD_LAT cycles later, the same cycle the Bank presents that beat's data.
  // It runs independently of the FSM, so a following burst cannot disturb it.
  assign tok_next[0] = (state_reg == READ);
  for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_tok
    assign tok_next[gi] = tok_reg[gi-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tok_reg <= '0;
    end else begin
      tok_reg <= tok_next;
    end
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rd_o_wr   = (state_reg == WRITE);
  assign wr_beat   = (state_reg == WRITE);
  assign dqin      = wr_data;
  assign row       = row_reg;
  assign column    = col_reg;
  assign rd_valid  = tok_reg[RD_LAT-1];
  // Gated so rd_data reads zero whenever no beat is being returned.
  assign rd_data   = rd_valid ? dqout : '0;
  assign busy      = (state_reg != IDLE) || (|tok_reg);

endmodule

// File: tb/tb_bank_burst_ctrl.sv
// Bench for bank_burst_ctrl: two instances (RD_LAT = 1 and 2) share one
// command stream and one Bank memory model. A cycle-indexed scoreboard built
// from the burst rules predicts every output each cycle; a few directed
// bursts pin the scoreboard against hand-computed literals.
module tb_bank_burst_ctrl;
  localparam int DW = 4;
  localparam int CW = 10;
  localparam int RW = 5;
  localparam int BW = 3;
  localparam int BL = 8;
  localparam int NC = 8192;
  localparam int NA = 1 << (RW + CW);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_wr = 1'b0;
  logic [RW-1:0] cmd_row = '0;
  logic [CW-1:0] cmd_col = '0;
  logic [DW-1:0] wr_data = '0;

  logic          cmd_ready [2];
  logic          wr_beat   [2];
  logic          rd_valid  [2];
  logic          rd_o_wr   [2];
  logic          busy      [2];
  logic [DW-1:0] rd_data   [2];
  logic [DW-1:0] dqin      [2];
  logic [DW-1:0] dqout     [2];
  logic [RW-1:0] row       [2];
  logic [CW-1:0] column    [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    bank_burst_ctrl #(
      .DEVICE_WIDTH(DW), .COLWIDTH(CW), .CHWIDTH(RW), .BLWIDTH(BW), .RD_LAT(gi + 1)
    ) u_dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[gi]), .cmd_wr(cmd_wr),
      .cmd_row(cmd_row), .cmd_col(cmd_col),
      .wr_data(wr_data), .wr_beat(wr_beat[gi]),
      .rd_data(rd_data[gi]), .rd_valid(rd_valid[gi]),
      .rd_o_wr(rd_o_wr[gi]), .dqin(dqin[gi]), .dqout(dqout[gi]),
      .row(row[gi]), .column(column[gi]), .busy(busy[gi])
    );
  end

  function automatic logic [DW-1:0] init_pat(int a);
    return DW'(a ^ (a >> 4) ^ (a >> 9));
  endfunction

  // Bank model: unwritten cells read a fixed address pattern.
  logic [DW-1:0] bank_mem  [NA];
  bit            bank_seen [NA];
  logic [DW-1:0] p1, p2;
  always @(posedge clk) begin
    int a;
    a = int'({row[0], column[0]});
    if (rd_o_wr[0]) begin
      bank_mem[a]  <= dqin[0];
      bank_seen[a] <= 1'b1;
    end
    p1 <= bank_seen[a] ? bank_mem[a] : init_pat(a);
    p2 <= p1;
  end
  assign dqout[0] = p1;
  assign dqout[1] = p2;

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  bit            sched_v   [NC];
  bit            sched_wr  [NC];
  logic [RW-1:0] sched_row [NC];
  logic [CW-1:0] sched_col [NC];
  bit            rdv [2][NC];
  logic [DW-1:0] rdd [2][NC];
  logic [DW-1:0] ref_mem  [NA];
  bit            ref_seen [NA];
  int            ready_at = 0;
  logic [RW-1:0] last_row = '0;
  logic [CW-1:0] last_col = '0;
  bit            chk_on = 1'b0;

  always @(negedge clk) begin
    int c, a, idx, cc, ed;
    bit er, bw, br, eb;
    c = cyc;
    if (sched_v[c]) begin
      last_row = sched_row[c];
      last_col = sched_col[c];
    end
    er = (c >= ready_at);
    bw = sched_v[c] && sched_wr[c];
    br = sched_v[c] && !sched_wr[c];
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        eb = !er || rdv[i][c] || (i == 1 && rdv[i][c+1]);
        ed = rdv[i][c] ? int'(rdd[i][c]) : 0;
        chk("cmd_ready", int'(cmd_ready[i]), int'(er));
        chk("busy",      int'(busy[i]),      int'(eb));
        chk("rd_o_wr",   int'(rd_o_wr[i]),   int'(bw));
        chk("wr_beat",   int'(wr_beat[i]),   int'(bw));
        chk("row",       int'(row[i]),       int'(last_row));
        chk("column",    int'(column[i]),    int'(last_col));
        chk("dqin",      int'(dqin[i]),      int'(wr_data));
        chk("rd_valid",  int'(rd_valid[i]),  int'(rdv[i][c]));
        chk("rd_data",   int'(rd_data[i]),   ed);
      end
    end
    a = int'({last_row, last_col});
    if (bw) begin
      ref_mem[a]  = wr_data;
      ref_seen[a] = 1'b1;
    end
    if (br) begin
      for (int i = 0; i < 2; i++) begin
        rdv[i][c+i+1] = 1'b1;
        rdd[i][c+i+1] = ref_seen[a] ? ref_mem[a] : init_pat(a);
      end
    end
    if (rst) begin
      for (int j = c + 1; j <= c + 16; j++) begin
        sched_v[j] = 1'b0;
        rdv[0][j]  = 1'b0;
        rdv[1][j]  = 1'b0;
      end
      last_row = '0;
      last_col = '0;
      ready_at = c + 1;
      chk_on   = 1'b1;
    end else if (cmd_valid && er) begin
      cc = int'(cmd_col);
      for (int k = 0; k < BL; k++) begin
        idx = c + 1 + k;
        sched_v[idx]   = 1'b1;
        sched_wr[idx]  = cmd_wr;
        sched_row[idx] = cmd_row;
        sched_col[idx] = CW'((cc / BL) * BL + ((cc % BL) + k) % BL);
      end
      ready_at = c + BL + 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(bit w, int r, int col);
    cmd_valid = 1'b1;
    cmd_wr    = w;
    cmd_row   = RW'(r);
    cmd_col   = CW'(col);
    next_cyc();
    cmd_valid = 1'b0;
  endtask

  int wcols [8] = '{'h005, 'h006, 'h007, 'h000, 'h001, 'h002, 'h003, 'h004};
  int hcols [8] = '{'h3FF, 'h3F8, 'h3F9, 'h3FA, 'h3FB, 'h3FC, 'h3FD, 'h3FE};

  initial begin
    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_rst_ready", int'(cmd_ready[0]), 1);
    chk("lit_rst_busy",  int'(busy[0]),      0);
    chk("lit_rst_col",   int'(column[0]),    0);
    next_cyc();

    // write row 3, critical column 0x005, data 1..8
    issue(1'b1, 3, 'h005);
    for (int k = 0; k < BL; k++) begin
      wr_data = DW'(k + 1);
      @(negedge clk);
      chk("lit_wcol", int'(column[0]),  wcols[k]);
      chk("lit_wrow", int'(row[0]),     3);
      chk("lit_wr",   int'(rd_o_wr[0]), 1);
      next_cyc();
    end

    // read it back: data 1..8 at latency 1 and 2
    issue(1'b0, 3, 'h005);
    for (int j = 0; j < 11; j++) begin
      @(negedge clk);
      chk("lit_rv1", int'(rd_valid[0]), int'(j >= 1 && j <= 8));
      if (j >= 1 && j <= 8) chk("lit_rd1", int'(rd_data[0]), j);
      chk("lit_rv2", int'(rd_valid[1]), int'(j >= 2 && j <= 9));
      if (j >= 2 && j <= 9) chk("lit_rd2", int'(rd_data[1]), j - 1);
      next_cyc();
    end

    // wrap at top of column space
    issue(1'b0, 1, 'h3FF);
    for (int k = 0; k < BL; k++) begin
      @(negedge clk);
      chk("lit_hcol", int'(column[0]), hcols[k]);
      next_cyc();
    end
    repeat (4) next_cyc();

    // read then write back-to-back with cmd_valid held high
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_row = RW'(2); cmd_col = CW'('h010);
    next_cyc();
    cmd_wr = 1'b1; cmd_col = CW'('h020);
    for (int j = 0; j < 10; j++) begin
      wr_data = DW'($urandom_range(0, 15));
      if (j == 3) cmd_row = RW'(6);
      @(negedge clk);
      chk("lit_b2b_ready", int'(cmd_ready[0]), int'(j == 8));
      chk("lit_b2b_wr",    int'(rd_o_wr[0]),   int'(j == 9));
      next_cyc();
      if (j == 8) cmd_valid = 1'b0;
    end
    repeat (10) begin
      wr_data = DW'($urandom_range(0, 15));
      next_cyc();
    end

    // reset at beat 3 of a read
    issue(1'b0, 3, 'h005);
    repeat (3) next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("lit_abort_rv1", int'(rd_valid[0]), 0);
      chk("lit_abort_rv2", int'(rd_valid[1]), 0);
      if (j == 0) begin
        chk("lit_abort_ready", int'(cmd_ready[0]), 1);
        chk("lit_abort_col",   int'(column[0]),    0);
      end
      next_cyc();
    end

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_wr    = 1'($urandom_range(0, 1));
      cmd_row   = RW'($urandom_range(0, 3));
      cmd_col   = CW'($urandom_range(0, 63));
      wr_data   = DW'($urandom_range(0, 15));
      rst       = ($urandom_range(0, 249) == 0);
      next_cyc();
    end
    rst = 1'b0;
    cmd_valid = 1'b0;
    repeat (12) next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
